// File: rtl/kernel_acc.sv
// kernel_acc: accumulates a COLS x COLS array of signed partial sums over a
// programmable channel count and holds the result for the bias stage.
// Optional saturating arithmetic is selected by defining KERNEL_ACC_SAT_EN.
module kernel_acc #(
    parameter int unsigned COLS  = 5,
    parameter int unsigned P_BW  = 16,
    parameter int unsigned AC_BW = 24,
    parameter int unsigned CH_BW = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        i_start,
    input  logic [CH_BW-1:0]            i_num_ch,
    input  logic                        i_valid,
    input  logic [P_BW*COLS*COLS-1:0]   i_psum,
    output logic                        o_ready,
    input  logic                        i_out_ready,
    output logic                        o_valid,
    output logic [AC_BW*COLS*COLS-1:0]  o_acc_kernel
);

    localparam int unsigned LANES = COLS * COLS;
    localparam int unsigned ACC_W = AC_BW * LANES;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CH_BW-1:0] cnt_q, cnt_d;
    logic [CH_BW-1:0] num_q, num_d;
    logic             valid_q, valid_d;

    logic [ACC_W-1:0] acc_sum;
    logic [CH_BW-1:0] cnt_inc;
    logic             start_job;

    // One lane of accumulate: wrap by default, clamp to the AC_BW range when saturating.
    function automatic logic [AC_BW-1:0] lane_add(input logic [AC_BW-1:0] acc,
                                                  input logic [P_BW-1:0]  ps);
`ifdef KERNEL_ACC_SAT_EN
        logic [AC_BW:0] sum;
        sum = {acc[AC_BW-1], acc} + (AC_BW+1)'(signed'(ps));
        if (sum[AC_BW] != sum[AC_BW-1]) begin
            lane_add = sum[AC_BW] ? {1'b1, {(AC_BW-1){1'b0}}} : {1'b0, {(AC_BW-1){1'b1}}};
        end else begin
            lane_add = sum[AC_BW-1:0];
        end
`else
        lane_add = acc + AC_BW'(signed'(ps));
`endif
    endfunction

    always_comb begin
        acc_sum = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            acc_sum[k*AC_BW +: AC_BW] = lane_add(acc_q[k*AC_BW +: AC_BW], i_psum[k*P_BW +: P_BW]);
        end
    end

    assign cnt_inc = cnt_q + CH_BW'(1);

    // Next-state and datapath updates; everything holds while en is low.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        valid_d   = valid_q;
        start_job = 1'b0;

        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) start_job = 1'b1;
                end
                S_ACC: begin
                    if (i_valid) begin
                        acc_d = acc_sum;
                        cnt_d = cnt_inc;
                        if (cnt_inc == num_q) begin
                            state_d = S_HOLD;
                            valid_d = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (i_out_ready) begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                        if (i_start) start_job = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end

        // A zero channel count skips ACC and presents the cleared array at once.
        if (start_job) begin
            acc_d = '0;
            num_d = i_num_ch;
            cnt_d = '0;
            if (i_num_ch == '0) begin
                state_d = S_HOLD;
                valid_d = 1'b1;
            end else begin
                state_d = S_ACC;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            valid_q <= valid_d;
        end
    end

    assign o_ready      = en && (state_q == S_ACC);
    assign o_valid      = valid_q;
    assign o_acc_kernel = acc_q;

endmodule

// File: doc/kernel_acc.md
# kernel_acc

Producer side of the biased-accumulator path. Accumulates a COLS×COLS array of signed partial sums over a programmable number of input channels, then presents the finished array on a packed bus formatted for the bias stage (`i_acc_kernel`). The block holds that bus stable, with `o_valid` high, until downstream acknowledges it.

## Interface
- `COLS`, 5: array dimension; COLS*COLS lanes.
- `P_BW`, 16: signed partial-sum width per lane.
- `AC_BW`, 24: signed accumulator width per lane. Requires AC_BW ≥ P_BW.
- `CH_BW`, 8: width of the channel-count input.

Ports:
- `clk`, input, 1: sole clock; rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: global enable. While low, all state, counters and outputs freeze.
- `i_start`, input, 1: begin a new accumulation.
- `i_num_ch`, input, CH_BW: number of channel beats to accumulate. Sampled on an accepted `i_start`.
- `i_valid`, input, 1: `i_psum` carries a valid beat.
- `i_psum`, input, P_BW*COLS*COLS: packed partial sums. Lane k = r*COLS+c sits at bits [(k+1)*P_BW-1 -: P_BW].
- `o_ready`, output, 1: block accepts a beat this cycle.
- `i_out_ready`, input, 1: downstream accepts the result.
- `o_valid`, output, 1: `o_acc_kernel` holds a finished result.
- `o_acc_kernel`, output, AC_BW*COLS*COLS: packed accumulators, lane k at [(k+1)*AC_BW-1 -: AC_BW]. Row r occupies slice [(r+1)*AC_BW*COLS-1 -: AC_BW*COLS].

## Operation
- **States:** IDLE, ACC, HOLD. Reset state is IDLE.
- **IDLE:** `o_ready`=0, `o_valid`=0. On `en && i_start`:
  - clear all accumulators to 0;
  - latch `i_num_ch`;
  - clear the channel counter;
  - go to ACC, or to HOLD directly if `i_num_ch`==0. A zero channel count yields an all-zero result.
- **ACC:** `o_ready` = `en`.
  - Beat accepted when `en && i_valid`.
  - Per lane: acc ← acc + sign_extend(psum lane, AC_BW). The counter increments.
  - The beat that brings the counter to the latched count moves the block to HOLD.
  - `i_start` is ignored in ACC.
- **HOLD:** `o_valid`=1, `o_ready`=0. `o_acc_kernel` is stable.
  - On `en && i_out_ready`: `o_valid` drops next cycle and the state goes to IDLE.
  - If `i_start` is also high in that cycle, the block starts the next job and goes straight to ACC (or stays in HOLD with a zero result if the count is 0). No idle bubble.
  - `i_start` without `i_out_ready` is ignored.
- **Arithmetic:** two's complement; default behaviour is modulo 2^AC_BW wrap (see Configuration).
- **Mid-operation reset:** `rst_n` low in any state forces IDLE immediately, with zero accumulators, zero counter and zero outputs. Any partial job is discarded.

## Timing
- **Reset values:** `o_valid`=0, `o_ready`=0, `o_acc_kernel`=0.
- `o_ready` is combinational from state and `en`.
- `o_acc_kernel` and `o_valid` are registered. `o_acc_kernel` is the accumulator register itself.
- Accumulation latency is 1 cycle per accepted beat. `o_valid` rises on the clock edge that accepts the final beat, so it is visible the cycle after that beat.
- **Job turnaround:**
  - `i_start` to first beat acceptance is 1 cycle: ACC is entered on the start edge.
  - With continuous `i_valid`, a job of N channels occupies N cycles in ACC plus at least 1 cycle in HOLD.
- Beats presented while `o_ready`=0 are not consumed. The upstream holds them.
- `en` low in HOLD keeps `o_valid` high and ignores `i_out_ready`.

## Configuration
- `KERNEL_ACC_SAT_EN` defined: each lane's sum is computed at AC_BW+1 bits and clamped to [-2^(AC_BW-1), 2^(AC_BW-1)-1]. Once saturated, a lane moves back only if later beats bring the sum back in range; the clamp is applied per beat.
- Undefined: each lane wraps modulo 2^AC_BW. No extra logic.

## Test plan
- **Basic sum:** reset, then start with num_ch=3; feed all lanes +100, +200, -50 on consecutive cycles → `o_valid` on the cycle after the third beat, every lane = 250, `o_ready` low in HOLD.
- **Lane mapping:** num_ch=1, lane k = k-12 (k=0..24) → lane 0 = -12, lane 24 = +12, each at bits [(k+1)*24-1 -: 24]; output held until `i_out_ready`, then `o_valid`=0 next cycle.
- **Stalls:**
  - num_ch=4 with `i_valid` gaps and one `en`=0 cycle mid-job; lane 0 = 32767 every beat → result 131068, and nothing is accepted while `en`=0;
  - `i_start` during ACC is ignored.
- **Back-to-back and zero count:**
  - HOLD with `i_out_ready`=1 and `i_start`=1 (num_ch=2, lanes 5, 7) → ACC the next cycle, result 12;
  - num_ch=0 → HOLD with all zeros.
- **Overflow:** 300 beats of -32768 (CH_BW=9) → with `KERNEL_ACC_SAT_EN` every lane = -8388608; without it, lane = -9830400 mod 2^24 = 6946816.
- **Reset mid-job:** assert `rst_n`=0 asynchronously in ACC after 2 beats → outputs zero immediately, state IDLE; a fresh start then gives a correct result.
